// File: rtl/beat_seq_pkg.sv
// Shared types and keycode constants for the beat sequencer.
package beat_seq_pkg;

  typedef enum logic [2:0] {
    StMain,
    StPlay,
    StSpawn,
    StWait,
    StFinish,
    StFail,
    StPass,
    StPause
  } state_e;

  localparam logic [7:0] KEY_SPACE = 8'd44;
  localparam logic [7:0] KEY_Q     = 8'd20;
  localparam logic [7:0] KEY_P     = 8'd19;

endpackage

// File: rtl/key_edge.sv
// Keycode register and key-event detect: a held key produces a single event.
module key_edge (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  output logic       key_event
);

  logic [7:0] prev_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= keycode;
    end
  end

  assign key_event = (keycode != 8'd0) && (keycode != prev_q);

endmodule

// File: rtl/beat_sequencer.sv
// Rhythm-game song sequencer: spawns one circle per beat and judges pass/fail at song end.
// Define BEAT_SEQ_PAUSE_EN to enable the p-key pause state.
module beat_sequencer
  import beat_seq_pkg::*;
#(
  parameter int unsigned NUM_BEATS   = 8,
  parameter int unsigned TYPE_W      = 2,
  parameter int unsigned HEALTH_W    = 4,
  parameter int unsigned PASS_HEALTH = 2,
  parameter int unsigned GAP_CYCLES  = 1024
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          out_of_bounds,
  input  logic [HEALTH_W-1:0]           health,
  input  logic [7:0]                    keycode,
  input  logic [NUM_BEATS*TYPE_W-1:0]   pattern,
  output logic                          main,
  output logic                          playbackground,
  output logic                          fail,
  output logic                          success,
  output logic                          spawn,
  output logic [TYPE_W-1:0]             circletype,
  output logic [$clog2(NUM_BEATS)-1:0]  beat_idx,
  output logic                          paused
);

  localparam int unsigned IdxW = $clog2(NUM_BEATS);
  localparam int unsigned CntW = $clog2(GAP_CYCLES);
  localparam logic [IdxW-1:0] LastBeat = IdxW'(NUM_BEATS - 1);
  localparam logic [CntW-1:0] LastGap  = CntW'(GAP_CYCLES - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            key_event;
  logic            space_ev, q_ev, abort;

  key_edge u_key_edge (
    .Clk       (Clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .key_event (key_event)
  );

  assign space_ev = key_event && (keycode == KEY_SPACE);
  assign q_ev     = key_event && (keycode == KEY_Q);
  assign abort    = q_ev || (health == '0);

`ifdef BEAT_SEQ_PAUSE_EN
  logic p_ev;
  assign p_ev = key_event && (keycode == KEY_P);
`endif

  // cnt_q counts cycles since the current beat spawned; every non-paused cycle advances it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      StMain: begin
        if (space_ev) begin
          state_d = StPlay;
          idx_d   = '0;
        end
      end
      StPlay: begin
        state_d = abort ? StFail : StSpawn;
        cnt_d   = '0;
      end
      StSpawn: begin
        cnt_d = CntW'(1);
        if (abort) state_d = StFail;
`ifdef BEAT_SEQ_PAUSE_EN
        else if (p_ev) state_d = StPause;
`endif
        else state_d = StWait;
      end
      StWait: begin
        cnt_d = (cnt_q == LastGap) ? cnt_q : cnt_q + CntW'(1);
        if (abort) state_d = StFail;
`ifdef BEAT_SEQ_PAUSE_EN
        else if (p_ev) state_d = StPause;
`endif
        else if (out_of_bounds || (cnt_q == LastGap)) begin
          if (idx_q == LastBeat) begin
            state_d = StFinish;
          end else begin
            state_d = StSpawn;
            idx_d   = idx_q + IdxW'(1);
            cnt_d   = '0;
          end
        end
      end
      StFinish: begin
        state_d = (health >= HEALTH_W'(PASS_HEALTH)) ? StPass : StFail;
      end
      StFail, StPass: begin
        if (space_ev) state_d = StMain;
      end
`ifdef BEAT_SEQ_PAUSE_EN
      StPause: begin
        if (q_ev) state_d = StFail;
        else if (p_ev) state_d = StWait;
      end
`endif
      default: state_d = StMain;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q after the edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q        <= StMain;
      idx_q          <= '0;
      cnt_q          <= '0;
      main           <= 1'b1;
      playbackground <= 1'b0;
      fail           <= 1'b0;
      success        <= 1'b0;
      spawn          <= 1'b0;
      circletype     <= '0;
`ifdef BEAT_SEQ_PAUSE_EN
      paused         <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      main           <= (state_d == StMain);
      playbackground <= state_d inside {StPlay, StSpawn, StWait, StFinish, StPause};
      fail           <= (state_d == StFail);
      success        <= (state_d == StPass);
      spawn          <= (state_d == StSpawn);
      circletype     <= (state_d == StSpawn) ? pattern[int'(idx_d) * TYPE_W +: TYPE_W] : '0;
`ifdef BEAT_SEQ_PAUSE_EN
      paused         <= (state_d == StPause);
`endif
    end
  end

`ifndef BEAT_SEQ_PAUSE_EN
  assign paused = 1'b0;
`endif

  assign beat_idx = idx_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Self-checking bench: songs are described as beat schedules and checked cycle by cycle.
module tb_beat_sequencer;

  localparam int NB  = 4;
  localparam int TW  = 2;
  localparam int HW  = 4;
  localparam int PH  = 2;
  localparam int GAP = 16;
`ifdef BEAT_SEQ_PAUSE_EN
  localparam bit PauseEn = 1'b1;
`else
  localparam bit PauseEn = 1'b0;
`endif

  logic             Clk = 1'b0;
  logic             Reset;
  logic             oob;
  logic [HW-1:0]    health;
  logic [7:0]       keycode;
  logic [NB*TW-1:0] pattern;
  logic             main, playbackground, fail, success, spawn, paused;
  logic [TW-1:0]    circletype;
  logic [1:0]       beat_idx;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Song description: per-beat gap (cycles from spawn to the deciding WAIT cycle).
  int         d[NB];
  bit         oob_en[NB];
  int         s[NB];
  int         fin;
  logic [7:0] pat;
  int         hsong, mode, tab, hold, pa, plen;

  beat_sequencer #(
    .NUM_BEATS   (NB),
    .TYPE_W      (TW),
    .HEALTH_W    (HW),
    .PASS_HEALTH (PH),
    .GAP_CYCLES  (GAP)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .out_of_bounds  (oob),
    .health         (health),
    .keycode        (keycode),
    .pattern        (pattern),
    .main           (main),
    .playbackground (playbackground),
    .fail           (fail),
    .success        (success),
    .spawn          (spawn),
    .circletype     (circletype),
    .beat_idx       (beat_idx),
    .paused         (paused)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic setup_default();
    for (int k = 0; k < NB; k++) begin
      d[k]      = GAP - 1;
      oob_en[k] = 1'b0;
    end
    pat   = 8'($urandom);
    hsong = 8;
    mode  = 0;
    tab   = 0;
    hold  = 1;
    pa    = -1;
    plen  = 0;
  endtask

  task automatic compute_schedule();
    s[0] = 2;
    for (int k = 1; k < NB; k++) s[k] = s[k-1] + d[k-1] + 1;
    fin = s[NB-1] + d[NB-1] + 1;
  endtask

  // Starts in MAIN at a cycle boundary; ends back in MAIN with keycode released.
  task automatic run_song(input string name);
    int         last_act, out_c, e, c, nspawn, exp_nspawn, exp_k;
    bit         succ, pact, in_pause, done, exp_spawn;
    logic [7:0] sh;
    last_act = (mode != 0) ? tab : fin;
    out_c    = last_act + 1;
    succ     = (mode == 0) && (hsong >= PH);
    pact     = PauseEn && (pa >= 0);
    pattern  = pat;
    nspawn   = 0;
    exp_nspawn = 0;
    for (int k = 0; k < NB; k++) if (s[k] <= last_act) exp_nspawn++;
    c = 0;
    done = 1'b0;
    while (!done) begin
      in_pause = pact && (c > pa) && (c <= pa + plen);
      e = (pact && c > pa + plen) ? c - plen : c;
      if (in_pause) begin
        check_eq({name, ".paused"}, paused, 1);
        check_eq({name, ".bg_pause"}, playbackground, 1);
        check_eq({name, ".spawn_pause"}, spawn, 0);
      end else begin
        exp_spawn = 1'b0;
        exp_k = 0;
        for (int k = 0; k < NB; k++)
          if (s[k] == e && s[k] <= last_act) begin
            exp_spawn = 1'b1;
            exp_k = k;
          end
        sh = pat >> (exp_k * TW);
        check_eq({name, ".main"}, main, (e == 0) || (e == out_c + 3));
        check_eq({name, ".bg"}, playbackground, (e >= 1) && (e <= last_act));
        check_eq({name, ".spawn"}, spawn, exp_spawn);
        check_eq({name, ".type"}, circletype, exp_spawn ? (sh & 8'(2**TW - 1)) : 0);
        check_eq({name, ".fail"}, fail, (e >= out_c) && (e <= out_c + 2) && !succ);
        check_eq({name, ".success"}, success, (e >= out_c) && (e <= out_c + 2) && succ);
        check_eq({name, ".paused0"}, paused, 0);
        if (exp_spawn) check_eq({name, ".beat_idx"}, beat_idx, exp_k);
      end
      check_eq({name, ".idx_range"}, beat_idx <= 2'(NB - 1), 1);
      if (spawn) nspawn++;
      keycode = 8'd0;
      oob     = 1'b0;
      health  = HW'(hsong);
      if (c < hold) keycode = 8'd44;
      if (pa >= 0 && (c == pa || c == pa + plen)) keycode = 8'd19;
      if (!in_pause) begin
        for (int k = 0; k < NB; k++) if (oob_en[k] && e == s[k] + d[k]) oob = 1'b1;
        if (mode == 1 && e == tab) keycode = 8'd20;
        if (mode == 2 && e == tab) begin
          health = '0;
          oob    = 1'b1;
        end
      end else if (c == pa + plen / 2) begin
        oob = 1'b1;
      end
      if (e == out_c + 2) keycode = 8'd44;
      done = (e == out_c + 3);
      tick();
      c++;
    end
    check_eq({name, ".spawn_count"}, nspawn, exp_nspawn);
  endtask

  initial begin
    Reset   = 1'b0;
    oob     = 1'b0;
    health  = 4'd8;
    keycode = 8'd0;
    pattern = '0;
    tick();
    tick();
    check_eq("rst.main", main, 1);
    check_eq("rst.bg", playbackground, 0);
    check_eq("rst.fail", fail, 0);
    check_eq("rst.success", success, 0);
    check_eq("rst.spawn", spawn, 0);
    check_eq("rst.type", circletype, 0);
    check_eq("rst.idx", beat_idx, 0);
    check_eq("rst.paused", paused, 0);
    Reset = 1'b1;
    tick();

    // Four beats, out_of_bounds 3 cycles after each spawn, space held for 5 cycles.
    setup_default();
    pat = 8'b11_10_01_00;
    for (int k = 0; k < NB; k++) begin
      d[k] = 3;
      oob_en[k] = 1'b1;
    end
    hsong = 3;
    hold  = 5;
    compute_schedule();
    run_song("pass4");

    setup_default();
    hsong = 1;
    compute_schedule();
    run_song("timeout_fail");

    setup_default();
    for (int k = 0; k < NB; k++) begin
      d[k] = 4;
      oob_en[k] = 1'b1;
    end
    compute_schedule();
    mode = 1;
    tab  = s[2] + 2;
    run_song("q_abort");

    setup_default();
    for (int k = 0; k < NB; k++) begin
      d[k] = 5;
      oob_en[k] = 1'b1;
    end
    compute_schedule();
    mode = 2;
    tab  = s[1] + d[1];
    run_song("health0");

    // p at gap count 5; paused for 100 cycles when the pause build is selected.
    setup_default();
    hsong = 9;
    pa    = 7;
    plen  = 100;
    compute_schedule();
    run_song("pause");

    // Reset mid-song abandons it without a spawn pulse.
    pattern = 8'hff;
    health  = 4'd8;
    keycode = 8'd44;
    tick();
    keycode = 8'd0;
    tick();
    check_eq("midrst.spawn_before", spawn, 1);
    tick();
    tick();
    #2 Reset = 1'b0;
    #1;
    check_eq("midrst.main", main, 1);
    check_eq("midrst.spawn", spawn, 0);
    check_eq("midrst.bg", playbackground, 0);
    check_eq("midrst.idx", beat_idx, 0);
    keycode = 8'd20;
    tick();
    check_eq("midrst.spawn_hold", spawn, 0);
    #2 Reset = 1'b1;
    tick();
    check_eq("midrst.main_rel", main, 1);
    check_eq("midrst.bg_rel", playbackground, 0);
    keycode = 8'd0;
    tick();
    check_eq("midrst.main_idle", main, 1);

    for (int n = 0; n < 40; n++) begin
      setup_default();
      for (int k = 0; k < NB; k++) begin
        if ($urandom_range(3, 0) == 0) begin
          d[k] = GAP - 1;
          oob_en[k] = 1'b0;
        end else begin
          d[k] = $urandom_range(GAP - 1, 1);
          oob_en[k] = 1'b1;
        end
      end
      hsong = $urandom_range(15, 1);
      hold  = $urandom_range(5, 1);
      compute_schedule();
      mode = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(2, 1);
      tab  = $urandom_range(fin - 1, hold);
      run_song("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/beat_sequencer.md
BEAT_SEQUENCER -- requirements
Module: beat_sequencer

Interface
REQ-001 SHALL have parameter NUM_BEATS, default 8, number of beats per song (2..256).
REQ-002 SHALL have parameter TYPE_W, default 2, circletype width.
REQ-003 SHALL have parameter HEALTH_W, default 4, health width.
REQ-004 SHALL have parameter PASS_HEALTH, default 2, minimum health at song end for pass.
REQ-005 SHALL have parameter GAP_CYCLES, default 1024, max cycles between beats (>=2).
REQ-006 SHALL have port Clk  in  1  sole clock.
REQ-007 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports out_of_bounds  in  1  circle missed/cleared pulse; health  in  HEALTH_W  player health; keycode  in  8  keyboard keycode.
REQ-009 SHALL have ports pattern  in  NUM_BEATS*TYPE_W  circletype of beat i at bits [i*TYPE_W +: TYPE_W].
REQ-010 SHALL have outputs main, playbackground, fail, success, spawn (1 each), circletype (TYPE_W), beat_idx ($clog2(NUM_BEATS)), paused (1).

Function
REQ-011 SHALL register keycode each cycle; a key event SHALL be keycode != 0 and keycode != previous registered keycode (held keys act once).
REQ-012 SHALL implement states MAIN, PLAY, SPAWN, WAIT, FINISH, FAIL, PASS (+PAUSE per REQ-024).
REQ-013 MAIN: space event (44) -> PLAY; beat_idx cleared to 0.
REQ-014 PLAY: one cycle, -> SPAWN.
REQ-015 SPAWN: one cycle, spawn=1, circletype=pattern slice for beat_idx; -> WAIT; gap counter cleared.
REQ-016 WAIT: gap counter increments; on out_of_bounds=1 or counter==GAP_CYCLES-1: if beat_idx==NUM_BEATS-1 -> FINISH, else beat_idx+1 and -> SPAWN.
REQ-017 PLAY/SPAWN/WAIT priority: q event (20) -> FAIL; else health==0 -> FAIL; else normal transition.
REQ-018 FINISH: one cycle; health>=PASS_HEALTH -> PASS else FAIL.
REQ-019 FAIL/PASS: space event -> MAIN; otherwise hold.
REQ-020 Outputs Moore from state: main=1 in MAIN; playbackground=1 in PLAY/SPAWN/WAIT/FINISH/PAUSE; fail=1 in FAIL; success=1 in PASS; spawn=1 only in SPAWN; circletype=0 outside SPAWN; paused=1 only in PAUSE.
REQ-021 Exactly one spawn pulse per beat; NUM_BEATS pulses per completed song; beat_idx never exceeds NUM_BEATS-1.

Reset
REQ-022 Reset=0 SHALL immediately force MAIN, beat_idx=0, gap counter=0, previous keycode=0; outputs main=1, all others 0.
REQ-023 Reset asserted mid-song SHALL abandon song without spawn pulse; release returns to MAIN regardless of keycode held.

Configuration
REQ-024 Macro BEAT_SEQ_PAUSE_EN defined: p event (19) in SPAWN/WAIT -> PAUSE (SPAWN's pulse still issued that cycle); PAUSE freezes gap counter and beat_idx, ignores out_of_bounds/health; p event -> WAIT; q event -> FAIL.
REQ-025 Macro undefined: no PAUSE state, keycode 19 ignored, paused tied 0.

Structure
REQ-026 Package beat_seq_pkg SHALL hold state enum and keycode constants KEY_SPACE=44, KEY_Q=20, KEY_P=19.
REQ-027 Sub-module key_edge (keycode register + event detect) SHALL be instantiated once.

Verification
REQ-028 Reset, space held 5 cycles -> exactly one MAIN->PLAY, single transition, main drops.
REQ-029 NUM_BEATS=4, pattern=8'b11_10_01_00, out_of_bounds pulse 3 cycles after each spawn, health=3 -> spawn with circletype 0,1,2,3, then success=1.
REQ-030 GAP_CYCLES=16, no out_of_bounds -> spawns 16 cycles apart; health=1 at end -> fail=1.
REQ-031 q event during WAIT beat 2 -> FAIL next cycle; no further spawn; space event -> MAIN.
REQ-032 health=0 during WAIT simultaneous with out_of_bounds -> FAIL, no spawn.
REQ-033 BEAT_SEQ_PAUSE_EN: p at gap count 5, hold 100 cycles, p again -> paused=1 throughout, next spawn GAP_CYCLES-5 cycles after resume.
